// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control sequencer for the multicycle MIPS datapath.
// Splits each instruction into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps and
// drives the datapath strobes as a pure decode of the current state.
//
// Optional feature: define MULTICYCLE_MEM_WAIT_EN to let FETCH, MEMRD and MEMWR
// stall on mem_ready. Without it mem_ready is ignored.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   Opcode[5:0]         IR[31:26], sampled in DECODE and MEMADR only
//   mem_ready           memory access complete (wait build only)
//   PCWrite..ALUSrcA    single-bit datapath strobes / mux selects
//   ALUSrcB, ALUOp, PCSrc  2-bit mux selects
//   retire              pulse on the last cycle of an instruction
//   illegal_op          pulse in DECODE for an unknown opcode
//   state[3:0]          current state, for debug
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12
  } state_e;

  state_e state_q, state_d;
  logic   mem_ok;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ok) state_d = StDecode;
      StDecode: begin
        case (Opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (Opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ok) state_d = StMemWb;
      StMemWr:  if (mem_ok) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
      default:  state_d = StIdle; // unused codes 13..15 recover to IDLE
    endcase
  end

  // Output decode; mem_ok is constant 1 in the non-wait build
  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = mem_ok;
        PCWrite = mem_ok;
        ALUSrcB = 2'b01;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OpLw, OpSw, OpR, OpBeq, OpAddi, OpJ: illegal_op = 1'b0;
          default:                             illegal_op = 1'b1;
        endcase
      end
      StMemAdr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ok;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        retire  = 1'b1;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StJump: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each instruction pushes its expected
// per-cycle state sequence into a scoreboard queue; every cycle one entry is
// popped and the DUT state, strobes and illegal_op are compared against it.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, retire, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  multicycle_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .Opcode     (Opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .retire     (retire),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_cnt, ret_cnt, pcw_cnt, irw_cnt;

  logic [16:0] got_ctrl;
  assign got_ctrl = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, retire};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected strobes for a state, written straight from the output table
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    logic pcw, br, iord, mr, mw, irw, m2r, rd, rw, asa, ret;
    logic [1:0] asb, aop, pcs;
    {pcw, br, iord, mr, mw, irw, m2r, rd, rw, asa, ret} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd1:        begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
      4'd2:        asb = 2'b11;
      4'd3, 4'd10: begin asa = 1; asb = 2'b10; end
      4'd4:        begin mr = 1; iord = 1; end
      4'd5:        begin m2r = 1; rw = 1; ret = 1; end
      4'd6:        begin mw = 1; iord = 1; ret = rdy; end
      4'd7:        begin asa = 1; aop = 2'b10; end
      4'd8:        begin rd = 1; rw = 1; ret = 1; end
      4'd9:        begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; ret = 1; end
      4'd11:       begin rw = 1; ret = 1; end
      4'd12:       begin pcw = 1; pcs = 2'b10; ret = 1; end
      default: ;
    endcase
    return {pcw, br, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ret};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic ill);
    exp_t e;
    e.st = st; e.rdy = rdy; e.ill = ill;
    q.push_back(e);
  endtask

  // Called at posedge+1; drives mem_ready for the cycle, compares at negedge
  task automatic step();
    exp_t e;
    e = q.pop_front();
    mem_ready = e.rdy;
    @(negedge clk);
    check_eq($sformatf("state@%0d", e.st), 32'(state), 32'(e.st));
    check_eq($sformatf("ctrl@%0d", e.st), 32'(got_ctrl), 32'(exp_ctrl(e.st, e.rdy)));
    check_eq($sformatf("illegal@%0d", e.st), 32'(illegal_op), 32'(e.ill));
    cyc_cnt++;
    if (retire)  ret_cnt++;
    if (PCWrite) pcw_cnt++;
    if (IRWrite) irw_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cyc_cnt = 0; ret_cnt = 0; pcw_cnt = 0; irw_cnt = 0;
    while (q.size() > 0) step();
  endtask

  task automatic do_instr(input logic [5:0] op, input int exp_lat, input string name);
    Opcode = op;
    push(4'd1, 1'b1, 1'b0);
    case (op)
      6'b100011: begin push(2, 1, 0); push(3, 1, 0); push(4, 1, 0); push(5, 1, 0); end
      6'b101011: begin push(2, 1, 0); push(3, 1, 0); push(6, 1, 0); end
      6'b000000: begin push(2, 1, 0); push(7, 1, 0); push(8, 1, 0); end
      6'b000100: begin push(2, 1, 0); push(9, 1, 0); end
      6'b001000: begin push(2, 1, 0); push(10, 1, 0); push(11, 1, 0); end
      6'b000010: begin push(2, 1, 0); push(12, 1, 0); end
      default:   push(2, 1, 1);
    endcase
    drain();
    check_eq({name, "_latency"}, 32'(cyc_cnt), 32'(exp_lat));
    check_eq({name, "_retires"}, 32'(ret_cnt), (exp_lat == 2) ? 32'd0 : 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    Opcode    = 6'b100011;

    // Reset held for three cycles: IDLE with every strobe low
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_ctrl", 32'(got_ctrl), 32'd0);
      check_eq("rst_illegal", 32'(illegal_op), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_instr(6'b100011, 5, "lw");
    do_instr(6'b000000, 4, "rtype");
    do_instr(6'b000100, 3, "beq");
    do_instr(6'b000010, 3, "j");
    do_instr(6'b001000, 4, "addi");
    do_instr(6'b101011, 4, "sw");
    do_instr(6'b111111, 2, "illegal");
    check_eq("illegal_pc_writes", 32'(pcw_cnt), 32'd1);

    // Abort a store in MEMWR with an asynchronous reset
    Opcode = 6'b101011;
    push(1, 1, 0); push(2, 1, 0); push(3, 1, 0);
    drain();
    check_eq("abort_in_memwr", 32'(state), 32'd6);
    check_eq("abort_memwrite_pre", 32'(MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_memwrite", 32'(MemWrite), 32'd0);
    check_eq("abort_retire", 32'(retire), 32'd0);
    check_eq("abort_state", 32'(state), 32'd0);
    @(negedge clk);
    check_eq("abort_retire_hold", 32'(retire), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_idle", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    do_instr(6'b000010, 3, "j_after_rst");

`ifdef MULTICYCLE_MEM_WAIT_EN
    // lw with two FETCH waits and three MEMRD waits
    Opcode = 6'b100011;
    push(1, 0, 0); push(1, 0, 0); push(1, 1, 0); push(2, 1, 0); push(3, 1, 0);
    push(4, 0, 0); push(4, 0, 0); push(4, 0, 0); push(4, 1, 0); push(5, 1, 0);
    drain();
    check_eq("wait_lw_latency", 32'(cyc_cnt), 32'd10);
    check_eq("wait_irwrite_cnt", 32'(irw_cnt), 32'd1);
    check_eq("wait_pcwrite_cnt", 32'(pcw_cnt), 32'd1);
    check_eq("wait_retires", 32'(ret_cnt), 32'd1);
    // sw with one MEMWR wait: retire only in the completing cycle
    Opcode = 6'b101011;
    push(1, 1, 0); push(2, 1, 0); push(3, 1, 0); push(6, 0, 0); push(6, 1, 0);
    drain();
    check_eq("wait_sw_latency", 32'(cyc_cnt), 32'd5);
    check_eq("wait_sw_retires", 32'(ret_cnt), 32'd1);
    mem_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
